// File: rtl/boot_fetch_ctrl.sv
// Boot fetch controller: waits for the ROM hash engine, checks the boot
// signature, then copies ROM words 1..NUM_WORDS-1 into destination memory.
module boot_fetch_ctrl #(
  parameter int          NUM_WORDS      = 7,
  parameter int          TIMEOUT_CYCLES = 256,
  parameter logic [31:0] BOOT_SIG       = 32'hCAFEBABE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        rom_cs,
  output logic        rom_read_en,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  input  logic        rom_hash_valid,
  input  logic        rom_boot_ready,
  output logic        dst_we,
  output logic [7:0]  dst_addr,
  output logic [31:0] dst_wdata,
  output logic        busy,
  output logic        boot_done,
  output logic        boot_fail,
  output logic [1:0]  err_code,
  output logic [31:0] checksum,
  output logic        cpu_rst_n
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WAIT_HASH = 3'd1;
  localparam logic [2:0] S_ADDR      = 3'd2;
  localparam logic [2:0] S_DATA      = 3'd3;
  localparam logic [2:0] S_DONE      = 3'd4;
  localparam logic [2:0] S_FAIL      = 3'd5;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_BAD_SIG = 2'b10;
  localparam logic [1:0] ERR_HASH    = 2'b11;

  localparam int          TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]  LAST_IDX = 8'(NUM_WORDS - 1);

  logic [2:0]    state_q,    state_d;
  logic [7:0]    idx_q,      idx_d;
  logic [TW-1:0] tmo_cnt_q,  tmo_cnt_d;
  logic [1:0]    err_code_q, err_code_d;
  logic [31:0]   checksum_q, checksum_d;
  logic          dst_we_q,   dst_we_d;
  logic [7:0]    dst_addr_q, dst_addr_d;
  logic [31:0]   dst_wdata_q, dst_wdata_d;

  // ROM protocol: the address is presented during ADDR, the ROM registers
  // the word, and it is sampled on the edge that ends DATA. Hash validity
  // must stay high for the whole copy or the boot is abandoned.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    tmo_cnt_d   = tmo_cnt_q;
    err_code_d  = err_code_q;
    checksum_d  = checksum_q;
    dst_we_d    = 1'b0;
    dst_addr_d  = dst_addr_q;
    dst_wdata_d = dst_wdata_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_WAIT_HASH;
          idx_d      = 8'd0;
          tmo_cnt_d  = '0;
          checksum_d = 32'd0;
        end
      end
      S_WAIT_HASH: begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
        // A ready ROM on the final allowed cycle still wins over the timeout.
        if (rom_hash_valid && rom_boot_ready) begin
          state_d = S_ADDR;
          idx_d   = 8'd0;
        end else if (tmo_cnt_q == TMO_LAST) begin
          state_d    = S_FAIL;
          err_code_d = ERR_TIMEOUT;
        end
      end
      S_ADDR: begin
        if (!rom_hash_valid) begin
          state_d    = S_FAIL;
          err_code_d = ERR_HASH;
        end else begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (!rom_hash_valid) begin
          state_d    = S_FAIL;
          err_code_d = ERR_HASH;
        end else if (idx_q == 8'd0 && rom_data != BOOT_SIG) begin
          state_d    = S_FAIL;
          err_code_d = ERR_BAD_SIG;
        end else begin
          if (idx_q != 8'd0) begin
            dst_we_d    = 1'b1;
            dst_addr_d  = idx_q - 8'd1;
            dst_wdata_d = rom_data;
            checksum_d  = checksum_q + rom_data;
          end
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 8'd1;
            state_d = S_ADDR;
          end
        end
      end
      S_DONE:  state_d = S_DONE;
      S_FAIL:  state_d = S_FAIL;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= 8'd0;
      tmo_cnt_q   <= '0;
      err_code_q  <= ERR_NONE;
      checksum_q  <= 32'd0;
      dst_we_q    <= 1'b0;
      dst_addr_q  <= 8'd0;
      dst_wdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      tmo_cnt_q   <= tmo_cnt_d;
      err_code_q  <= err_code_d;
      checksum_q  <= checksum_d;
      dst_we_q    <= dst_we_d;
      dst_addr_q  <= dst_addr_d;
      dst_wdata_q <= dst_wdata_d;
    end
  end

  logic rom_active;
  logic copying;

  always_comb begin
    rom_active  = (state_q == S_WAIT_HASH) || (state_q == S_ADDR) || (state_q == S_DATA);
    copying     = (state_q == S_ADDR) || (state_q == S_DATA);
    rom_cs      = rom_active;
    rom_read_en = rom_active;
    rom_addr    = copying ? {22'b0, idx_q, 2'b00} : 32'd0;
    busy        = rom_active;
    boot_done   = (state_q == S_DONE);
    boot_fail   = (state_q == S_FAIL);
    cpu_rst_n   = (state_q == S_DONE);
    err_code    = err_code_q;
    checksum    = checksum_q;
    dst_we      = dst_we_q;
    dst_addr    = dst_addr_q;
    dst_wdata   = dst_wdata_q;
  end

endmodule
